// File: rtl/sd_pkg.sv
// Shared state encoding, command indices and frame widths for the SD SPI command engine.
// Serial CRC7 generation is selected with the SD_CRC7_EN macro.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SEND,
    ST_WAIT,
    ST_R1,
    ST_DATA,
    ST_POST,
    ST_DONE
  } sd_state_e;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD58  = 6'd58;

  localparam int FRAME_W   = 48;
  localparam int TRAILER_W = 32;
  localparam int PAD_BITS  = 8;

  // Fixed CRCs: only CMD0 and CMD8 are CRC-checked by a card still in SPI init.
  function automatic logic [6:0] crc7_const(input logic [5:0] idx);
    case (idx)
      CMD0:    return 7'h4A;
      CMD8:    return 7'h43;
      default: return 7'h7F;
    endcase
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, init 0) over the command frame, one bit per enable.
// Instantiated only when SD_CRC7_EN is defined.
module sd_crc7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;

  assign fb = din ^ crc[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    end
  end

endmodule

// File: rtl/sd_spi_cmd.sv
// SPI-mode SD command engine: sends one 48-bit command frame and collects the R1 / R3 / R7 response.
// Define SD_CRC7_EN for a computed CRC7; otherwise a per-command constant CRC is sent.
//
// state | meaning
// IDLE  | waiting for cmd_valid, cmd_ready high
// PRE   | cs_n low, 8 clocks with mosi high
// SEND  | shifting the 48-bit command frame out MSB first
// WAIT  | clocking ones, looking for the R1 start bit (bounded by RESP_WAIT bytes)
// R1    | shifting the remaining 7 R1 bits
// DATA  | shifting the 32-bit R3/R7 trailer
// POST  | cs_n high, 8 trailing clocks
// DONE  | one-cycle resp_valid
module sd_spi_cmd
  import sd_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int RESP_WAIT = 8
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic        resp_len,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_data,
  output logic        resp_timeout,
  output logic        busy,
  output logic        sd_clk,
  output logic        sd_cs_n,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  localparam int WAIT_BITS = RESP_WAIT * 8;
  localparam int CNT_MAX   = (WAIT_BITS > FRAME_W) ? WAIT_BITS : FRAME_W;
  localparam int CNT_W     = $clog2(CNT_MAX);
  localparam int HALF_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  sd_state_e         state_q, state_d;
  logic [HALF_W-1:0] half_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              rdy_q;
  logic              hit_q;
  logic              resp_len_q;
  logic [39:0]       frame_sr;
  logic [6:0]        crc7;
  logic [7:0]        tail;
  logic              accept, active, half_tc, sd_rise, bit_end, bit_last;

  function automatic logic [CNT_W-1:0] bits_for(input sd_state_e s);
    case (s)
      ST_PRE, ST_POST: return CNT_W'(PAD_BITS - 1);
      ST_SEND:         return CNT_W'(FRAME_W - 1);
      ST_WAIT:         return CNT_W'(WAIT_BITS - 1);
      ST_R1:           return CNT_W'(6);
      ST_DATA:         return CNT_W'(TRAILER_W - 1);
      default:         return '0;
    endcase
  endfunction

  assign accept     = cmd_valid && cmd_ready;
  assign active     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign half_tc    = active && (half_cnt == '0);
  assign sd_rise    = half_tc && !sd_clk;
  assign bit_end    = half_tc && sd_clk;
  assign bit_last   = bit_end && (bit_cnt == '0);

  assign cmd_ready  = rdy_q && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);

  // The last 8 frame bits come from the CRC, not from the shift register.
  assign tail    = {crc7, 1'b1};
  assign sd_mosi = (state_q != ST_SEND)      ? 1'b1 :
                   (bit_cnt >= CNT_W'(8))    ? frame_sr[39] : tail[bit_cnt[2:0]];

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_PRE;
      ST_PRE:  if (bit_last) state_d = ST_SEND;
      ST_SEND: if (bit_last) state_d = ST_WAIT;
      ST_WAIT: begin
        if (bit_end && hit_q) state_d = ST_R1;
        else if (bit_last)    state_d = ST_POST;
      end
      ST_R1:   if (bit_last) state_d = resp_len_q ? ST_DATA : ST_POST;
      ST_DATA: if (bit_last) state_d = ST_POST;
      ST_POST: if (bit_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      half_cnt <= HALF_W'(CLK_DIV - 1);
      sd_clk   <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      if (!active || (half_cnt == '0)) half_cnt <= HALF_W'(CLK_DIV - 1);
      else                             half_cnt <= half_cnt - 1'b1;
      if (half_tc) sd_clk <= !sd_clk;
      if (state_d != state_q) bit_cnt <= bits_for(state_d);
      else if (bit_end)       bit_cnt <= bit_cnt - 1'b1;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      rdy_q        <= 1'b0;
      sd_cs_n      <= 1'b1;
      hit_q        <= 1'b0;
      resp_len_q   <= 1'b0;
      frame_sr     <= '0;
      resp_r1      <= 8'hFF;
      resp_data    <= '0;
      resp_timeout <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        sd_cs_n      <= 1'b0;
        resp_len_q   <= resp_len;
        frame_sr     <= {2'b01, cmd_idx, cmd_arg};
        resp_r1      <= 8'hFF;
        resp_timeout <= 1'b0;
        hit_q        <= 1'b0;
        if (!resp_len) resp_data <= '0;
      end
      if ((state_d == ST_POST) && (state_q != ST_POST)) sd_cs_n <= 1'b1;
      if ((state_q == ST_SEND) && bit_end) frame_sr <= {frame_sr[38:0], 1'b0};
      // The first zero seen while waiting is R1 bit 7.
      if ((state_q == ST_WAIT) && sd_rise && !sd_miso) begin
        hit_q   <= 1'b1;
        resp_r1 <= {resp_r1[6:0], 1'b0};
      end
      if ((state_q == ST_WAIT) && bit_last && !hit_q) begin
        resp_timeout <= 1'b1;
        resp_r1      <= 8'hFF;
      end
      if ((state_q == ST_R1) && sd_rise)   resp_r1   <= {resp_r1[6:0], sd_miso};
      if ((state_q == ST_DATA) && sd_rise) resp_data <= {resp_data[30:0], sd_miso};
    end
  end

`ifdef SD_CRC7_EN
  sd_crc7 u_crc7 (
    .clk (sclk),
    .rst (rst),
    .clr (accept),
    .en  ((state_q == ST_SEND) && bit_end && (bit_cnt >= CNT_W'(8))),
    .din (frame_sr[39]),
    .crc (crc7)
  );
`else
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      crc7 <= '0;
    end else if (accept) begin
      crc7 <= crc7_const(cmd_idx);
    end
  end
`endif

endmodule

// File: tb/tb_sd_spi_cmd.sv
// Bench for sd_spi_cmd: a bit-level SD card model plus a stream-level reference for frame, response and timing.
module tb_sd_spi_cmd;

  localparam int CLK_DIV   = 2;
  localparam int RESP_WAIT = 8;
  localparam int WBITS     = RESP_WAIT * 8;
  localparam int PER       = 10;

  logic        sclk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [5:0]  cmd_idx = '0;
  logic [31:0] cmd_arg = '0;
  logic        resp_len = 1'b0;
  logic        sd_miso = 1'b1;
  logic        cmd_ready, resp_valid, resp_timeout, busy, sd_clk, sd_cs_n, sd_mosi;
  logic [7:0]  resp_r1;
  logic [31:0] resp_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit resp_bits[$];
  bit mosi_bits[$];
  int k = 0;
  int post_clks = 0;
  int rv_count = 0;
  longint t_rise = 0;
  longint t_fall = 0;
  logic [31:0] model_data = '0;
  logic [47:0] last_frame = '0;

  sd_spi_cmd #(.CLK_DIV(CLK_DIV), .RESP_WAIT(RESP_WAIT)) dut (
    .sclk(sclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .resp_len(resp_len),
    .resp_valid(resp_valid), .resp_r1(resp_r1), .resp_data(resp_data),
    .resp_timeout(resp_timeout), .busy(busy), .sd_clk(sd_clk),
    .sd_cs_n(sd_cs_n), .sd_mosi(sd_mosi), .sd_miso(sd_miso)
  );

  always #(PER/2) sclk = ~sclk;

  // Card: records MOSI on sd_clk rise and presents the next response bit right after it.
  always @(posedge sd_clk or posedge sd_cs_n) begin
    if (!sd_clk) begin
      k = 0;
      sd_miso = 1'b1;
    end else if (sd_cs_n) begin
      post_clks++;
    end else begin
      mosi_bits.push_back(sd_mosi);
      k++;
      sd_miso = (k >= 56 && (k - 56) < resp_bits.size()) ? resp_bits[k - 56] : 1'b1;
    end
  end

  always @(posedge sd_cs_n) t_rise = $time;
  always @(negedge sd_cs_n) t_fall = $time;
  always @(negedge sclk) if (resp_valid) rv_count++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  function automatic bit bit_at(input int i);
    return (i < resp_bits.size()) ? resp_bits[i] : 1'b1;
  endfunction

  function automatic logic [6:0] ref_crc(input logic [5:0] idx, input logic [31:0] arg);
`ifdef SD_CRC7_EN
    logic [46:0] r;
    r = {2'b01, idx, arg, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
`else
    if (idx == 6'd0) return 7'h4A;
    if (idx == 6'd8) return 7'h43;
    return 7'h7F;
`endif
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 2000) begin @(negedge sclk); n++; end
    check("ready_wait", cmd_ready, 1);
  endtask

  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic len,
                         input int off, input logic [7:0] r1, input logic [31:0] data, input bit hold);
    int cyc, z, nbits, post0, rv0, zeros;
    logic [7:0]  exp_r1;
    logic [31:0] exp_d;
    logic [47:0] got_f;
    resp_bits.delete();
    for (int i = 0; i < off; i++) resp_bits.push_back(1'b1);
    for (int i = 7; i >= 0; i--) resp_bits.push_back(r1[i]);
    if (len) for (int i = 31; i >= 0; i--) resp_bits.push_back(data[i]);
    wait_ready();
    mosi_bits.delete();
    post0 = post_clks;
    rv0 = rv_count;
    cmd_idx = idx; cmd_arg = arg; resp_len = len; cmd_valid = 1'b1;
    @(posedge sclk); #1;
    if (!hold) cmd_valid = 1'b0;
    check("accept_cs_n", {busy, cmd_ready, sd_cs_n}, 3'b100);
    cyc = 0;
    do begin @(negedge sclk); cyc++; end while (!resp_valid && cyc < 5000);

    z = -1;
    for (int i = 0; i < WBITS; i++) if (bit_at(i) == 1'b0) begin z = i; break; end
    if (z < 0) begin
      exp_r1 = 8'hFF;
      exp_d  = len ? model_data : 32'h0;
      nbits  = 8 + 48 + WBITS + 8;
    end else begin
      for (int i = 0; i < 8; i++) exp_r1[7 - i] = bit_at(z + i);
      for (int i = 0; i < 32; i++) exp_d[31 - i] = len ? bit_at(z + 8 + i) : 1'b0;
      nbits = 8 + 48 + (z + 1) + 7 + (len ? 32 : 0) + 8;
    end
    model_data = exp_d;

    check("resp_latency", cyc, nbits * 2 * CLK_DIV + 1);
    check("resp_r1", resp_r1, exp_r1);
    check("resp_data", resp_data, exp_d);
    check("resp_timeout", resp_timeout, (z < 0));
    check("cs_low_bits", mosi_bits.size(), nbits - 8);
    got_f = 'x;
    if (mosi_bits.size() >= 56) for (int i = 0; i < 48; i++) got_f = {got_f[46:0], mosi_bits[8 + i]};
    last_frame = got_f;
    check("mosi_frame", got_f, {2'b01, idx, arg, ref_crc(idx, arg), 1'b1});
    zeros = 0;
    for (int i = 0; i < mosi_bits.size(); i++) if ((i < 8 || i >= 56) && !mosi_bits[i]) zeros++;
    check("mosi_idle_zeros", zeros, 0);
    @(negedge sclk);
    check("resp_valid_pulse", {resp_valid, sd_cs_n}, 2'b01);
    check("resp_valid_count", rv_count - rv0, 1);
    check("post_clocks", post_clks - post0, 8);
  endtask

  initial begin
    int n;
    logic [5:0]  ridx;
    logic [31:0] rarg, rdat;
    logic        rlen;
    logic [7:0]  rr1;
    int          roff;

    repeat (3) @(negedge sclk);
    check("rst_outputs", {sd_clk, sd_cs_n, sd_mosi, cmd_ready, busy, resp_valid, resp_timeout}, 7'b0110000);
    check("rst_r1_data", {resp_r1, resp_data}, {8'hFF, 32'h0});
    rst = 1'b0;
    @(negedge sclk);
    check("ready_after_rst", cmd_ready, 1);

    run_txn(6'd0, 32'h0, 1'b0, 16, 8'h01, 32'h0, 1'b0);
    run_txn(6'd8, 32'h0000_01AA, 1'b1, 16, 8'h01, 32'h0000_01AA, 1'b0);
    check("cmd8_last_byte", last_frame[7:0], 8'h87);
    run_txn(6'd0, 32'h0, 1'b0, 80, 8'hFF, 32'h0, 1'b0);
    run_txn(6'd41, 32'h4000_0000, 1'b0, WBITS - 1, 8'h00, 32'h0, 1'b0);
    run_txn(6'd58, 32'h0, 1'b1, WBITS, 8'h00, 32'hC0FF_8000, 1'b0);
`ifdef SD_CRC7_EN
    run_txn(6'd17, 32'h0, 1'b0, 8, 8'h00, 32'h0, 1'b0);
    check("cmd17_crc_byte", last_frame[7:0], 8'h55);
`endif

    // Reset in the middle of SEND.
    wait_ready();
    cmd_idx = 6'd0; cmd_arg = '0; resp_len = 1'b0; cmd_valid = 1'b1;
    @(posedge sclk); #1 cmd_valid = 1'b0;
    repeat (60) @(negedge sclk);
    check("mid_send_busy", {busy, sd_cs_n}, 2'b10);
    n = rv_count;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outputs", {sd_cs_n, sd_clk, busy, cmd_ready, resp_valid, sd_mosi}, 6'b100001);
    repeat (3) @(negedge sclk);
    rst = 1'b0;
    @(negedge sclk);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_no_valid", rv_count - n, 0);
    run_txn(6'd0, 32'h0, 1'b0, 5, 8'h01, 32'h0, 1'b0);

    // cmd_valid held: the second frame only starts after DONE.
    run_txn(6'd55, 32'h0, 1'b0, 3, 8'h01, 32'h0, 1'b1);
    n = 0;
    while (sd_cs_n && n < 200) begin @(negedge sclk); n++; end
    cmd_valid = 1'b0;
    check("held_second_accept", sd_cs_n, 0);
    check("held_cs_gap", (t_fall - t_rise) >= longint'(8 * 2 * CLK_DIV * PER), 1);
    n = 0;
    while (!resp_valid && n < 5000) begin @(negedge sclk); n++; end
    check("held_second_r1", {resp_valid, resp_r1}, {1'b1, 8'h01});
    @(negedge sclk);

    for (int t = 0; t < 8; t++) begin
      ridx = 6'($urandom_range(0, 63));
      rarg = $urandom;
      rlen = 1'($urandom_range(0, 1));
      rr1  = 8'($urandom);
      rdat = $urandom;
      roff = $urandom_range(0, WBITS + 4);
      run_txn(ridx, rarg, rlen, roff, rr1, rdat, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_spi_cmd.md
SD_SPI_CMD -- requirements
Module: sd_spi_cmd

Interface
REQ-001 Parameter CLK_DIV, default 2: sclk cycles per sd_clk half-period (>=1).
REQ-002 Parameter RESP_WAIT, default 8: maximum response-wait bytes (NCR).
REQ-003 sclk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request; accepted when cmd_valid and cmd_ready are both high.
REQ-006 cmd_ready  out  1  high only in IDLE.
REQ-007 cmd_idx  in  6  command index; captured on accept.
REQ-008 cmd_arg  in  32  command argument; captured on accept.
REQ-009 resp_len  in  1  0 = R1 only; 1 = R1 + 32-bit trailer (R3/R7); captured on accept.
REQ-010 resp_valid  out  1  one-cycle pulse when a transaction completes.
REQ-011 resp_r1  out  8  R1 byte; held until next accept.
REQ-012 resp_data  out  32  R3/R7 trailer, MSB first; held until next accept.
REQ-013 resp_timeout  out  1  no response start bit seen; valid with resp_valid.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 sd_clk  out  1  SPI clock, idles low (mode 0).
REQ-016 sd_cs_n  out  1  card select, active low.
REQ-017 sd_mosi  out  1  serial data to card; idles high.
REQ-018 sd_miso  in  1  serial data from card.

Function
REQ-019 Bit period: 2*CLK_DIV sclk cycles; sd_clk low for the first half, high for the second half.
REQ-020 sd_mosi changes only while sd_clk is low; sd_miso is sampled on the sclk edge that drives sd_clk high.
REQ-021 States: IDLE, PRE, SEND, WAIT, R1, DATA, POST, DONE.
REQ-022 IDLE -> PRE on accept; sd_cs_n goes low in the same edge; the command frame is latched.
REQ-023 PRE: 8 clocks with sd_mosi=1, then -> SEND.
REQ-024 SEND: 48-bit frame {2'b01, cmd_idx, cmd_arg, crc7, 1'b1}, MSB first, then -> WAIT.
REQ-025 WAIT: clock with sd_mosi=1 and search for the first sampled 0 bit, which is R1 bit 7.
REQ-026 WAIT transitions: 0 bit found -> R1; RESP_WAIT*8 bits elapsed without a 0 -> POST with resp_timeout=1 and resp_r1=8'hFF.
REQ-027 R1: shift 7 more bits; then -> DATA if resp_len=1, else -> POST.
REQ-028 DATA: shift 32 bits into resp_data, then -> POST.
REQ-029 POST: sd_cs_n goes high, 8 clocks with sd_mosi=1, then -> DONE.
REQ-030 DONE: pulse resp_valid for one cycle, then -> IDLE.
REQ-031 cmd_valid outside IDLE is ignored and has no effect.
REQ-032 resp_timeout is cleared on accept.
REQ-033 resp_data is cleared on accept when resp_len=0.

Reset
REQ-034 While rst is high: state=IDLE, sd_clk=0, sd_cs_n=1, sd_mosi=1, cmd_ready=0, busy=0, resp_valid=0, resp_r1=8'hFF, resp_data=0, resp_timeout=0.
REQ-035 cmd_ready rises in the first cycle after reset release.
REQ-036 Reset asserted mid-transaction forces the reset values immediately (asynchronously), with no resp_valid pulse.

Configuration
REQ-037 With SD_CRC7_EN defined: crc7 is computed serially (polynomial x^7+x^3+1, init 0) over the first 40 frame bits.
REQ-038 Without SD_CRC7_EN: crc7 is a constant, 7'h4A for cmd_idx=0, 7'h43 for cmd_idx=8, and 7'h7F otherwise.

Structure
REQ-039 Shared package sd_pkg holds the state enumeration, command index constants (CMD0, CMD8, CMD55, ACMD41, CMD58), the frame width (48) and the response trailer width (32).
REQ-040 One sub-module, sd_crc7 (serial CRC7, enable/clear/bit inputs), is instantiated only under SD_CRC7_EN.

Verification
REQ-041 CMD0, arg 0, resp_len=0, card returns 0x01 after 2 filler bytes -> MOSI bytes 40 00 00 00 00 95; resp_r1=0x01; resp_timeout=0; exactly one resp_valid.
REQ-042 CMD8, arg 0x000001AA, resp_len=1, card returns 01 00 00 01 AA -> MOSI bytes 48 00 00 01 AA 87; resp_r1=0x01; resp_data=0x000001AA.
REQ-043 sd_miso held high -> resp_timeout=1, resp_r1=0xFF; resp_valid occurs after 8+48+RESP_WAIT*8+8 bit periods.
REQ-044 rst pulsed mid-SEND -> sd_cs_n=1, sd_clk=0, no resp_valid; the next CMD0 completes normally.
REQ-045 cmd_valid held through a transaction -> a second transaction starts only after the DONE cycle, with cs_n high for at least 8 bit periods between frames.
REQ-046 With SD_CRC7_EN, CMD17 arg 0 -> final frame byte 0x55.
